branch_predict_unit: RTL and testbench

BRANCH_PREDICT_UNIT -- requirements
Module: branch_predict_unit

---
 rtl/branch_predict_unit.sv | 152 +++++++++++++++
 tb/tb_branch_predict_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_unit.sv
// Branch prediction unit: direct-mapped BTB with saturating counters and a
// circular return-address stack.
//
// The fetch-side lookup is combinational and reads the table as it stands
// before the current edge. Resolve-side updates from decode are committed on
// the rising clock edge.
//
// Ports
//   clock, reset_n                  sole clock (rising edge), async active-low reset
//   f_valid, f_pc                   fetch lookup request and PC
//   pred_taken, pred_target         prediction for f_pc (f_pc+4 when not taken)
//   r_valid, r_pc, r_is_branch      resolve strobe, PC, branch/jump qualifier
//   r_taken, r_target               actual outcome and target
//   r_link, r_is_return             writes $ra / is JR $ra
//   r_pred_taken, r_pred_target     prediction carried down the pipe
//   mispredict                      redirect/flush request
//   ras_empty                       return-address stack holds no entries
module branch_predict_unit #(
    parameter int ENTRIES   = 16,
    parameter int CTR_BITS  = 2,
    parameter int RAS_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        f_valid,
    input  logic [31:0] f_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        r_valid,
    input  logic [31:0] r_pc,
    input  logic        r_is_branch,
    input  logic        r_taken,
    input  logic [31:0] r_target,
    input  logic        r_link,
    input  logic        r_is_return,
    input  logic        r_pred_taken,
    input  logic [31:0] r_pred_target,
    output logic        mispredict,
    output logic        ras_empty
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    // Weakly-taken: only the MSB set.
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_MAX ^ (CTR_MAX >> 1);

    logic                btb_valid  [ENTRIES];
    logic [TAG_W-1:0]    btb_tag    [ENTRIES];
    logic [31:0]         btb_target [ENTRIES];
    logic [CTR_BITS-1:0] btb_ctr    [ENTRIES];
    logic                btb_is_ret [ENTRIES];

    logic [31:0]         ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ras_ptr;   // index of the current top entry
    logic [CNT_W-1:0]    ras_cnt;

    // Fetch-side lookup
    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    assign f_idx = f_pc[IDX_W+1:2];
    assign f_tag = f_pc[31:IDX_W+2];
    assign f_hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

    assign ras_empty = (ras_cnt == '0);

    always_comb begin
        pred_taken  = f_valid & f_hit & (btb_ctr[f_idx][CTR_BITS-1] | btb_is_ret[f_idx]);
        pred_target = f_pc + 32'd4;
        if (pred_taken) begin
            if (btb_is_ret[f_idx] && !ras_empty)
                pred_target = ras_mem[ras_ptr];
            else
                pred_target = btb_target[f_idx];
        end
    end

    assign mispredict = r_valid & ((r_pred_taken != r_taken) |
                                   (r_taken & (r_pred_target != r_target)));

    // Resolve-side update
    logic             upd;
    logic [IDX_W-1:0] r_idx;
    logic [TAG_W-1:0] r_tag;
    logic             r_hit;
    logic             ras_push;
    logic             ras_pop;
    logic [31:0]      link_addr;

    assign upd       = r_valid & r_is_branch;
    assign r_idx     = r_pc[IDX_W+1:2];
    assign r_tag     = r_pc[31:IDX_W+2];
    assign r_hit     = btb_valid[r_idx] && (btb_tag[r_idx] == r_tag);
    assign link_addr = r_pc + 32'd4;
    assign ras_push  = upd & r_link & r_taken;
    // A pop on an empty stack is dropped here so it cannot disturb a push.
    assign ras_pop   = upd & r_is_return & (ras_cnt != '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                btb_valid[i]  <= 1'b0;
                btb_tag[i]    <= '0;
                btb_target[i] <= '0;
                btb_ctr[i]    <= '0;
                btb_is_ret[i] <= 1'b0;
            end
        end else if (upd) begin
            if (r_hit) begin
                if (r_taken) begin
                    btb_target[r_idx] <= r_target;
                    if (btb_ctr[r_idx] != CTR_MAX)
                        btb_ctr[r_idx] <= btb_ctr[r_idx] + 1'b1;
                end else if (btb_ctr[r_idx] != '0) begin
                    btb_ctr[r_idx] <= btb_ctr[r_idx] - 1'b1;
                end
            end else if (r_taken) begin
                btb_valid[r_idx]  <= 1'b1;
                btb_tag[r_idx]    <= r_tag;
                btb_target[r_idx] <= r_target;
                btb_ctr[r_idx]    <= CTR_INIT;
                btb_is_ret[r_idx] <= r_is_return;
            end
        end
    end

    // Circular stack: a push when full lands on the oldest slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
            for (int i = 0; i < RAS_DEPTH; i++)
                ras_mem[i] <= '0;
        end else if (ras_push && ras_pop) begin
            ras_mem[ras_ptr] <= link_addr;
        end else if (ras_push) begin
            ras_mem[ras_ptr + PTR_W'(1)] <= link_addr;
            ras_ptr <= ras_ptr + PTR_W'(1);
            if (ras_cnt != CNT_W'(RAS_DEPTH))
                ras_cnt <= ras_cnt + CNT_W'(1);
        end else if (ras_pop) begin
            ras_ptr <= ras_ptr - PTR_W'(1);
            ras_cnt <= ras_cnt - CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        f_valid;
    logic [31:0] f_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        r_valid;
    logic [31:0] r_pc;
    logic        r_is_branch;
    logic        r_taken;
    logic [31:0] r_target;
    logic        r_link;
    logic        r_is_return;
    logic        r_pred_taken;
    logic [31:0] r_pred_target;
    logic        mispredict;
    logic        ras_empty;

    int n_checks = 0;
    int n_fail   = 0;

    branch_predict_unit #(.ENTRIES(16), .CTR_BITS(2), .RAS_DEPTH(4)) dut (
        .clock(clock), .reset_n(reset_n),
        .f_valid(f_valid), .f_pc(f_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .r_valid(r_valid), .r_pc(r_pc), .r_is_branch(r_is_branch),
        .r_taken(r_taken), .r_target(r_target), .r_link(r_link),
        .r_is_return(r_is_return), .r_pred_taken(r_pred_taken),
        .r_pred_target(r_pred_target), .mispredict(mispredict),
        .ras_empty(ras_empty)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        fv;
        logic [31:0] fpc;
        logic        rv;
        logic [31:0] rpc;
        logic        rbr;
        logic        rtk;
        logic [31:0] rtgt;
        logic        rlink;
        logic        rret;
        logic        rpt;
        logic [31:0] rptgt;
        logic        e_pt;
        logic [31:0] e_tgt;
        logic        e_mis;
        logic        e_empty;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] fpc,
                         input logic rv, input logic [31:0] rpc, input logic rbr,
                         input logic rtk, input logic [31:0] rtgt, input logic rlink,
                         input logic rret, input logic rpt, input logic [31:0] rptgt);
        f_valid = fv;  f_pc = fpc;
        r_valid = rv;  r_pc = rpc;  r_is_branch = rbr;  r_taken = rtk;
        r_target = rtgt;  r_link = rlink;  r_is_return = rret;
        r_pred_taken = rpt;  r_pred_target = rptgt;
    endtask

    // Lookup only, at the next negedge; checked 2 time units later.
    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic e_pt, input logic [31:0] e_tgt, input logic e_empty);
        @(negedge clock);
        drive(1, pc, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check({name, " pred_taken"}, 32'(pred_taken), 32'(e_pt));
        check({name, " pred_target"}, pred_target, e_tgt);
        check({name, " ras_empty"}, 32'(ras_empty), 32'(e_empty));
    endtask

    // Resolve only (no lookup), committed at the following posedge.
    task automatic resolve(input logic [31:0] rpc, input logic rtk, input logic [31:0] rtgt,
                           input logic rlink, input logic rret);
        @(negedge clock);
        drive(0, 0, 1, rpc, 1, rtk, rtgt, rlink, rret, rtk, rtgt);
    endtask

    logic [31:0] ras_exp [4];

    initial begin
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        //          fv  fpc           rv  rpc           br tk rtgt          lk rt pt ptgt          e_pt e_tgt        mis emp
        vecs[0]  = '{1, 32'h0040_0010, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0014, 0, 1};
        vecs[1]  = '{1, 32'h0040_0010, 1, 32'h0040_0010, 1, 1, 32'h0040_0100, 0, 0, 0, 32'h0,        0, 32'h0040_0014, 1, 1};
        vecs[2]  = '{1, 32'h0040_0010, 1, 32'h0040_0010, 1, 0, 32'h0,        0, 0, 1, 32'h0040_0100, 1, 32'h0040_0100, 1, 1};
        vecs[3]  = '{1, 32'h0040_0010, 1, 32'h0040_0010, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0014, 0, 1};
        vecs[4]  = '{1, 32'h0040_0010, 1, 32'h0040_0010, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0014, 0, 1};
        vecs[5]  = '{1, 32'h0040_0010, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0014, 0, 1};
        vecs[6]  = '{1, 32'h0040_0010, 1, 32'h0040_0010, 1, 1, 32'h0040_0100, 0, 0, 0, 32'h0,        0, 32'h0040_0014, 1, 1};
        vecs[7]  = '{1, 32'h0040_0010, 1, 32'h0040_0010, 1, 1, 32'h0040_0100, 0, 0, 0, 32'h0,        0, 32'h0040_0014, 1, 1};
        vecs[8]  = '{1, 32'h0040_0010, 1, 32'h0040_0010, 1, 1, 32'h0040_0200, 0, 0, 1, 32'h0040_0100, 1, 32'h0040_0100, 1, 1};
        vecs[9]  = '{1, 32'h0040_0010, 1, 32'h0040_0010, 1, 1, 32'h0040_0200, 0, 0, 1, 32'h0040_0200, 1, 32'h0040_0200, 0, 1};
        vecs[10] = '{1, 32'h0040_0020, 1, 32'h0040_0020, 1, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0024, 0, 1};
        vecs[11] = '{0, 32'h0040_0010, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0014, 0, 1};
        vecs[12] = '{1, 32'h0040_0020, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0024, 0, 1};
        vecs[13] = '{1, 32'h0040_0010, 1, 32'h0040_0050, 1, 1, 32'h0040_0500, 0, 0, 0, 32'h0,        1, 32'h0040_0200, 1, 1};
        vecs[14] = '{1, 32'h0040_0010, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0014, 0, 1};
        vecs[15] = '{1, 32'h0040_0050, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        1, 32'h0040_0500, 0, 1};
        vecs[16] = '{1, 32'h0040_0030, 1, 32'h0040_0030, 0, 1, 32'h0040_0700, 0, 0, 0, 32'h0,        0, 32'h0040_0034, 1, 1};
        vecs[17] = '{1, 32'h0040_0030, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0, 32'h0,        0, 32'h0040_0034, 0, 1};

        ras_exp[0] = 32'h504; ras_exp[1] = 32'h404; ras_exp[2] = 32'h304; ras_exp[3] = 32'h204;

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            drive(vecs[i].fv, vecs[i].fpc, vecs[i].rv, vecs[i].rpc, vecs[i].rbr, vecs[i].rtk,
                  vecs[i].rtgt, vecs[i].rlink, vecs[i].rret, vecs[i].rpt, vecs[i].rptgt);
            #2;
            check($sformatf("v%0d pred_taken", i), 32'(pred_taken), 32'(vecs[i].e_pt));
            check($sformatf("v%0d pred_target", i), pred_target, vecs[i].e_tgt);
            check($sformatf("v%0d mispredict", i), 32'(mispredict), 32'(vecs[i].e_mis));
            check($sformatf("v%0d ras_empty", i), 32'(ras_empty), 32'(vecs[i].e_empty));
        end

        // Return entry allocated while the stack is empty: the pop is ignored.
        resolve(32'h0040_0084, 1, 32'h0000_1234, 0, 1);
        lookup("ret empty", 32'h0040_0084, 1, 32'h0000_1234, 1);

        // Five pushes into a four-deep stack: the oldest (0x104) is overwritten.
        for (int k = 1; k <= 5; k++)
            resolve(32'(k * 32'h100), 1, 32'h0000_9000, 1, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            drive(1, 32'h0040_0084, 1, 32'h0040_0084, 1, 1, ras_exp[k], 0, 1, 1, ras_exp[k]);
            #2;
            check($sformatf("pop%0d pred_target", k), pred_target, ras_exp[k]);
            check($sformatf("pop%0d ras_empty", k), 32'(ras_empty), 32'd0);
            check($sformatf("pop%0d mispredict", k), 32'(mispredict), 32'd0);
        end
        lookup("ras drained", 32'h0040_0084, 1, 32'h0000_0204, 1);

        // Pop on empty, then a single push must be the top.
        resolve(32'h0040_0084, 1, 32'h0000_0204, 0, 1);
        resolve(32'h0000_0600, 1, 32'h0000_9000, 1, 0);
        lookup("after push", 32'h0040_0084, 1, 32'h0000_0604, 0);
        // Simultaneous push and pop replaces the top; count stays at one.
        resolve(32'h0000_0700, 1, 32'h0000_9000, 1, 1);
        lookup("push+pop", 32'h0040_0084, 1, 32'h0000_0704, 0);
        resolve(32'h0040_0084, 1, 32'h0000_0704, 0, 1);
        lookup("single pop", 32'h0040_0084, 1, 32'h0000_0704, 1);

        // Reset asserted in the middle of a resolve cycle.
        resolve(32'h0000_0800, 1, 32'h0000_9000, 1, 0);
        lookup("pre reset", 32'h0040_0084, 1, 32'h0000_0804, 0);
        @(negedge clock);
        drive(1, 32'h0040_0084, 1, 32'h0040_00C0, 1, 1, 32'h0040_0900, 1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("in reset pred_taken", 32'(pred_taken), 32'd0);
        check("in reset ras_empty", 32'(ras_empty), 32'd1);
        @(posedge clock);
        @(negedge clock);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_n = 1'b1;
        lookup("post reset ret", 32'h0040_0084, 0, 32'h0040_0088, 1);
        lookup("post reset alias", 32'h0040_0050, 0, 32'h0040_0054, 1);
        lookup("post reset upd", 32'h0040_00C0, 0, 32'h0040_00C4, 1);
        lookup("post reset old", 32'h0040_0010, 0, 32'h0040_0014, 1);

        // Normal operation resumes after reset.
        resolve(32'h0040_0010, 1, 32'h0040_0100, 0, 0);
        lookup("resume", 32'h0040_0010, 1, 32'h0040_0100, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
